// File: rtl/shift_univ_nb_if.sv
// Bus bundle for shift_univ_nb: control, serial and parallel data in, taps and status out.
// Latency: none, wires only.
// Backpressure: none, the register accepts an operation every cycle.
//
// Signals: load/lshift/rshift/rot select the operation; in_l/in_r are the serial entry words.
// par_in/par_out are all stages packed (stage i at [i*BUS_WIDTH +: BUS_WIDTH]).
// out_l/out_r and their _vld bits are the exit taps; vld/fill_cnt track occupancy.
// err flags a conflicting shift request.
interface shift_univ_nb_if #(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                         load;
    logic                         lshift;
    logic                         rshift;
    logic                         rot;
    logic [BUS_WIDTH-1:0]         in_l;
    logic [BUS_WIDTH-1:0]         in_r;
    logic [DEPTH*BUS_WIDTH-1:0]   par_in;
    logic [BUS_WIDTH-1:0]         out_l;
    logic [BUS_WIDTH-1:0]         out_r;
    logic                         out_l_vld;
    logic                         out_r_vld;
    logic [DEPTH*BUS_WIDTH-1:0]   par_out;
    logic [DEPTH-1:0]             vld;
    logic [CNT_W-1:0]             fill_cnt;
    logic                         err;

    // Side that drives operations and observes the register.
    modport master (
        output load, lshift, rshift, rot, in_l, in_r, par_in,
        input  out_l, out_r, out_l_vld, out_r_vld, par_out, vld, fill_cnt, err
    );

    // The shift register itself.
    modport slave (
        input  load, lshift, rshift, rot, in_l, in_r, par_in,
        output out_l, out_r, out_l_vld, out_r_vld, par_out, vld, fill_cnt, err
    );
endinterface

// File: rtl/shift_univ_nb.sv
// Universal shift register of DEPTH words: left/right shift, rotate and parallel load.
// Latency: one cycle per operation; a word needs DEPTH-1 further shifts to reach the far exit.
// Backpressure: none; every posedge applies RST > LOAD > single shift > hold.
//
// Ports: CLK, RST (synchronous, active high), bus (shift_univ_nb_if.slave).
// Every output is a register or a direct stage tap, so nothing combinational runs from input to output.
module shift_univ_nb #(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic           CLK,
    input  logic           RST,
    shift_univ_nb_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BUS_WIDTH-1:0] stg_q [DEPTH];
    logic [BUS_WIDTH-1:0] stg_d [DEPTH];
    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH-1:0]     vld_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 err_q;
    logic                 err_d;

    always_comb begin
        stg_d = stg_q;
        vld_d = vld_q;
        err_d = 1'b0;
        if (bus.load) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_d[i] = bus.par_in[i*BUS_WIDTH +: BUS_WIDTH];
            end
            vld_d = '1;
        end else if (bus.lshift && !bus.rshift) begin
            for (int i = 1; i < DEPTH; i++) begin
                stg_d[i] = stg_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
            // Rotation recirculates the exiting word together with its valid bit.
            stg_d[0] = bus.rot ? stg_q[DEPTH-1] : bus.in_l;
            vld_d[0] = bus.rot ? vld_q[DEPTH-1] : 1'b1;
        end else if (bus.rshift && !bus.lshift) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stg_d[i] = stg_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            stg_d[DEPTH-1] = bus.rot ? stg_q[0] : bus.in_r;
            vld_d[DEPTH-1] = bus.rot ? vld_q[0] : 1'b1;
        end else if (bus.rshift && bus.lshift) begin
            // Conflicting directions: contents hold, flag it for one cycle.
            err_d = 1'b1;
        end
    end

    // Occupancy is a popcount of the next valid vector, so it can never drift from VLD.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(vld_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            stg_q <= stg_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_par
        assign bus.par_out[g*BUS_WIDTH +: BUS_WIDTH] = stg_q[g];
    end

    assign bus.out_l     = stg_q[DEPTH-1];
    assign bus.out_r     = stg_q[0];
    assign bus.out_l_vld = vld_q[DEPTH-1];
    assign bus.out_r_vld = vld_q[0];
    assign bus.vld       = vld_q;
    assign bus.fill_cnt  = cnt_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_shift_univ_nb.sv
// Self-checking bench for shift_univ_nb (BUS_WIDTH=8, DEPTH=4).
// Latency: checks sample 1 time unit after each posedge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_shift_univ_nb;
    localparam int BW = 8;
    localparam int D  = 4;
    localparam int W  = BW * D;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Reference state: the register viewed as one packed word plus a valid vector.
    logic [W-1:0] m_par = '0;
    logic [D-1:0] m_vld = '0;
    logic         m_err = 1'b0;

    always #5 CLK = ~CLK;

    shift_univ_nb_if #(.BUS_WIDTH(BW), .DEPTH(D)) bus ();

    shift_univ_nb #(.BUS_WIDTH(BW), .DEPTH(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Drive one operation, advance one edge and update the reference model.
    task automatic step(input logic r, input logic ld, input logic ls, input logic rs,
                        input logic rt, input logic [BW-1:0] il, input logic [BW-1:0] ir,
                        input logic [W-1:0] pin);
        logic [BW-1:0] win;
        logic          vin;
        RST = r; bus.load = ld; bus.lshift = ls; bus.rshift = rs;
        bus.rot = rt; bus.in_l = il; bus.in_r = ir; bus.par_in = pin;
        @(posedge CLK);
        if (r) begin
            m_par = '0; m_vld = '0; m_err = 1'b0;
        end else if (ld) begin
            m_par = pin; m_vld = '1; m_err = 1'b0;
        end else if (ls && !rs) begin
            win   = rt ? m_par[W-1 -: BW] : il;
            vin   = rt ? m_vld[D-1] : 1'b1;
            m_par = (m_par << BW) | W'(win);
            m_vld = (m_vld << 1) | D'(vin);
            m_err = 1'b0;
        end else if (rs && !ls) begin
            win   = rt ? m_par[BW-1:0] : ir;
            vin   = rt ? m_vld[0] : 1'b1;
            m_par = (m_par >> BW) | (W'(win) << (BW * (D - 1)));
            m_vld = (m_vld >> 1) | (D'(vin) << (D - 1));
            m_err = 1'b0;
        end else begin
            m_err = ls && rs;
        end
        #1;
        RST = 1'b0; bus.load = 1'b0; bus.lshift = 1'b0; bus.rshift = 1'b0; bus.rot = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hFFFF_FFFF);
        n_total++;
        if ({bus.par_out, bus.vld, bus.fill_cnt, bus.err} !== {32'h0, 4'b0000, 3'd0, 1'b0})
            $display("FAIL reset: par_out=%h vld=%b fill=%0d err=%b, want 0/0000/0/0",
                     bus.par_out, bus.vld, bus.fill_cnt, bus.err);
        else n_pass++;
    endtask

    task automatic test_lshift_fill();
        logic [BW-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, words[i], 8'h00, 32'h0);
            if (i == 0) begin
                n_total++;
                if (bus.fill_cnt !== 3'd1 || bus.out_l_vld !== 1'b0)
                    $display("FAIL lshift_first: fill=%0d out_l_vld=%b, want 1/0", bus.fill_cnt, bus.out_l_vld);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.par_out !== 32'h1122_3344 || bus.out_l !== 8'h11 || bus.out_l_vld !== 1'b1 || bus.fill_cnt !== 3'd4)
            $display("FAIL lshift_full: par_out=%h out_l=%h vld=%b fill=%0d, want 11223344/11/1/4",
                     bus.par_out, bus.out_l, bus.out_l_vld, bus.fill_cnt);
        else n_pass++;
    endtask

    task automatic test_rotate();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hA1B2_C3D4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hEE, 32'h0);
        n_total++;
        if (bus.par_out !== 32'hD4A1_B2C3 || bus.out_r !== 8'hC3 || bus.vld !== 4'b1111)
            $display("FAIL rotate_one: par_out=%h out_r=%h vld=%b, want D4A1B2C3/C3/1111",
                     bus.par_out, bus.out_r, bus.vld);
        else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hEE, 32'h0);
        n_total++;
        if (bus.par_out !== 32'hA1B2_C3D4)
            $display("FAIL rotate_full: par_out=%h, want A1B2C3D4", bus.par_out);
        else n_pass++;
    endtask

    task automatic test_rshift();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 32'h0);
        n_total++;
        if (bus.vld !== 4'b1000 || bus.out_l !== 8'h5A || bus.out_r_vld !== 1'b0 || bus.fill_cnt !== 3'd1)
            $display("FAIL rshift_first: vld=%b out_l=%h out_r_vld=%b fill=%0d, want 1000/5A/0/1",
                     bus.vld, bus.out_l, bus.out_r_vld, bus.fill_cnt);
        else n_pass++;
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'(i), 32'h0);
        n_total++;
        if (bus.out_r !== 8'h5A || bus.out_r_vld !== 1'b1)
            $display("FAIL rshift_exit: out_r=%h out_r_vld=%b, want 5A/1", bus.out_r, bus.out_r_vld);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 32'h0);
        n_total++;
        if (bus.out_r !== 8'h01 || bus.par_out !== 32'h0403_0201 || bus.vld !== 4'b1111)
            $display("FAIL rshift_drop: out_r=%h par_out=%h vld=%b, want 01/04030201/1111",
                     bus.out_r, bus.par_out, bus.vld);
        else n_pass++;
    endtask

    task automatic test_err();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h1234_5678);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'hBB, 32'h0);
        n_total++;
        if (bus.par_out !== 32'h1234_5678 || bus.err !== 1'b1 || bus.fill_cnt !== 3'd4)
            $display("FAIL err_set: par_out=%h err=%b fill=%0d, want 12345678/1/4",
                     bus.par_out, bus.err, bus.fill_cnt);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
        n_total++;
        if (bus.err !== 1'b0 || bus.par_out !== 32'h1234_5678)
            $display("FAIL err_pulse: err=%b par_out=%h, want 0/12345678", bus.err, bus.par_out);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'hBB, 32'hCAFE_F00D);
        n_total++;
        if (bus.par_out !== 32'hCAFE_F00D || bus.err !== 1'b0)
            $display("FAIL err_load: par_out=%h err=%b, want CAFEF00D/0", bus.par_out, bus.err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 32'h0);
        n_total++;
        if (bus.fill_cnt !== 3'd4)
            $display("FAIL rst_pre_full: fill=%0d, want 4", bus.fill_cnt);
        else n_pass++;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 32'h0);
        n_total++;
        if (bus.par_out !== 32'h0 || bus.fill_cnt !== 3'd0 || bus.vld !== 4'b0000)
            $display("FAIL rst_with_shift: par_out=%h fill=%0d vld=%b, want 0/0/0000",
                     bus.par_out, bus.fill_cnt, bus.vld);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0BAD_BEEF);
        #2;
        RST = 1'b1;
        #1;
        n_total++;
        if (bus.par_out !== 32'h0BAD_BEEF || bus.fill_cnt !== 3'd4)
            $display("FAIL rst_midcycle: par_out=%h fill=%0d, want 0BADBEEF/4", bus.par_out, bus.fill_cnt);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
        n_total++;
        if (bus.par_out !== 32'h0 || bus.fill_cnt !== 3'd0)
            $display("FAIL rst_edge: par_out=%h fill=%0d, want 0/0", bus.par_out, bus.fill_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int op;
        logic [W+D+3+1+BW+BW+2-1:0] got, want;
        for (int c = 0; c < 300; c++) begin
            op = $urandom_range(0, 19);
            step(op == 0, op inside {[1:2]}, op inside {[3:10], 17}, op inside {[11:17]},
                 1'($urandom), 8'($urandom), 8'($urandom), 32'($urandom));
            got  = {bus.par_out, bus.vld, bus.fill_cnt, bus.err, bus.out_l, bus.out_r,
                    bus.out_l_vld, bus.out_r_vld};
            want = {m_par, m_vld, 3'($countones(m_vld)), m_err, m_par[W-1 -: BW], m_par[BW-1:0],
                    m_vld[D-1], m_vld[0]};
            n_total++;
            if (got !== want)
                $display("FAIL random cycle %0d op %0d: got %h, want %h", c, op, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.lshift = 1'b0; bus.rshift = 1'b0; bus.rot = 1'b0;
        bus.in_l = '0; bus.in_r = '0; bus.par_in = '0;
        test_reset();
        test_lshift_fill();
        test_rotate();
        test_rshift();
        test_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
